rv_instr_encoder: RTL and testbench

//  Streaming RV32I instruction encoder and instruction-memory loader: the encode-side counterpart of the core's

---
 rtl/rv_instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: packs symbolic ops into 32-bit words and writes them to instruction memory.
// Define ENC_RANGE_CHECK_EN to flag out-of-range immediates in err (words are still written).
`timescale 1ns/1ps
module rv_instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [4:0]        op_code,
  input  logic [4:0]        op_rd,
  input  logic [4:0]        op_rs1,
  input  logic [4:0]        op_rs2,
  input  logic [31:0]       op_imm,
  input  logic              op_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam int unsigned       SUM_W    = ADDR_W + 2;
  localparam logic [CNT_W-1:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_J   = 3'd4;
  localparam logic [2:0] F_U   = 3'd5;
  localparam logic [2:0] F_BAD = 3'd6;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              busy_q, done_q, full_q;

  logic [2:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        imm_bad;
  logic        enc_err;
  logic        accept;

  // Op-code to format / opcode / funct3 / funct7 lookup
  always_comb begin
    fmt = F_BAD;
    opc = 7'd0;
    f3  = 3'd0;
    f7  = 7'd0;
    case (op_code)
      5'd0:  begin fmt = F_R; opc = 7'b0110011; end
      5'd1:  begin fmt = F_R; opc = 7'b0110011; f7 = 7'b0100000; end
      5'd2:  begin fmt = F_R; opc = 7'b0110011; f3 = 3'b010; end
      5'd3:  begin fmt = F_R; opc = 7'b0110011; f3 = 3'b011; end
      5'd4:  begin fmt = F_R; opc = 7'b0110011; f3 = 3'b110; end
      5'd5:  begin fmt = F_R; opc = 7'b0110011; f3 = 3'b111; end
      5'd6:  begin fmt = F_I; opc = 7'b0000011; f3 = 3'b010; end
      5'd7:  begin fmt = F_I; opc = 7'b0010011; end
      5'd8:  begin fmt = F_I; opc = 7'b0010011; f3 = 3'b010; end
      5'd9:  begin fmt = F_I; opc = 7'b0010011; f3 = 3'b011; end
      5'd10: begin fmt = F_I; opc = 7'b0010011; f3 = 3'b100; end
      5'd11: begin fmt = F_I; opc = 7'b0010011; f3 = 3'b110; end
      5'd12: begin fmt = F_I; opc = 7'b1100111; end
      5'd13: begin fmt = F_S; opc = 7'b0100011; f3 = 3'b010; end
      5'd14: begin fmt = F_J; opc = 7'b1101111; end
      5'd15: begin fmt = F_B; opc = 7'b1100011; end
      5'd16: begin fmt = F_B; opc = 7'b1100011; f3 = 3'b001; end
      5'd17: begin fmt = F_B; opc = 7'b1100011; f3 = 3'b100; end
      5'd18: begin fmt = F_B; opc = 7'b1100011; f3 = 3'b101; end
      5'd19: begin fmt = F_U; opc = 7'b0110111; end
      default: ;
    endcase
  end

  // Word assembly; unused fields stay zero, immediates are truncated to their field
  always_comb begin
    enc_word = NOP_WORD;
    imm_bad  = 1'b0;
    case (fmt)
      F_R: enc_word = {f7, op_rs2, op_rs1, f3, op_rd, opc};
      F_I: enc_word = {op_imm[11:0], op_rs1, f3, op_rd, opc};
      F_S: enc_word = {op_imm[11:5], op_rs2, op_rs1, f3, op_imm[4:0], opc};
      F_B: enc_word = {op_imm[12], op_imm[10:5], op_rs2, op_rs1, f3, op_imm[4:1], op_imm[11], opc};
      F_J: enc_word = {op_imm[20], op_imm[10:1], op_imm[11], op_imm[19:12], op_rd, opc};
      F_U: enc_word = {op_imm[31:12], op_rd, opc};
      default: enc_word = NOP_WORD;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      F_I, F_S: imm_bad = (op_imm[31:11] != {21{op_imm[11]}});
      F_B:      imm_bad = (op_imm[31:12] != {20{op_imm[12]}}) || op_imm[0];
      F_J:      imm_bad = (op_imm[31:20] != {12{op_imm[20]}}) || op_imm[0];
      F_U:      imm_bad = |op_imm[11:0];
      default:  imm_bad = 1'b0;
    endcase
`endif
  end

  assign enc_err = (fmt == F_BAD) || imm_bad;

  // A write still in flight counts against capacity so the last slot is never over-committed
  assign op_ready = (state_q == S_RUN) && !start &&
                    ((SUM_W'(count_q) + SUM_W'(we_q)) < SUM_W'(CAPACITY));
  assign accept   = op_valid && op_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (start) begin
      state_d = S_RUN;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (we_q) begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + CNT_W'(1);
        if ((state_q == S_RUN) && (count_d == CAPACITY)) state_d = S_FULL;
      end
      if (accept) begin
        we_d    = 1'b1;
        wdata_d = enc_word;
        err_d   = err_q | enc_err;
        if (op_last) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      full_q  <= (state_d == S_FULL);
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: an 8-bit-address and a 2-bit-address instance share stimulus and are
// checked every cycle against a transaction-level model plus literal instruction words.
`timescale 1ns/1ps
module tb_rv_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic start, op_valid, op_last;
  logic [4:0] op_code, op_rd, op_rs1, op_rs2;
  logic [31:0] op_imm;

  logic o_rdy[2], o_we[2], o_busy[2], o_done[2], o_full[2], o_err[2];
  logic [31:0] o_wd[2], o_addr[2], o_cnt[2];
  logic [7:0] a_addr;
  logic [8:0] a_cnt;
  logic [1:0] b_addr;
  logic [2:0] b_cnt;

  assign o_addr[0] = 32'(a_addr);
  assign o_cnt[0]  = 32'(a_cnt);
  assign o_addr[1] = 32'(b_addr);
  assign o_cnt[1]  = 32'(b_cnt);

  always #5 clk = ~clk;

  rv_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(o_rdy[0]),
    .op_code(op_code), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
    .op_last(op_last), .imem_we(o_we[0]), .imem_addr(a_addr), .imem_wdata(o_wd[0]),
    .busy(o_busy[0]), .done(o_done[0]), .full(o_full[0]), .err(o_err[0]), .count(a_cnt));

  rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(o_rdy[1]),
    .op_code(op_code), .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
    .op_last(op_last), .imem_we(o_we[1]), .imem_addr(b_addr), .imem_wdata(o_wd[1]),
    .busy(o_busy[1]), .done(o_done[1]), .full(o_full[1]), .err(o_err[1]), .count(b_cnt));

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2, ST_FULL = 3;
  int cap[2] = '{256, 4};
  int m_st[2], m_cnt[2], m_addr[2];
  bit m_we[2], m_err[2];
  logic [31:0] m_wd[2];
  int wr_seen[2];
  int checks = 0, errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference encoding: field placement by shifts/masks of the RV32I layouts
  function automatic logic [31:0] golden(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm, output bit bad);
    logic [31:0] opc, f3, f7, regs;
    int fmt;
    int sv;
    bit ok;
    sv = int'(imm);
    ok = 1'b1;
    bad = 1'b0;
    f3 = 0; f7 = 0; opc = 0; fmt = 6;
    case (int'(op))
      0: begin fmt = 0; opc = 32'h33; end
      1: begin fmt = 0; opc = 32'h33; f7 = 32'h20; end
      2: begin fmt = 0; opc = 32'h33; f3 = 2; end
      3: begin fmt = 0; opc = 32'h33; f3 = 3; end
      4: begin fmt = 0; opc = 32'h33; f3 = 6; end
      5: begin fmt = 0; opc = 32'h33; f3 = 7; end
      6: begin fmt = 1; opc = 32'h03; f3 = 2; end
      7: begin fmt = 1; opc = 32'h13; end
      8: begin fmt = 1; opc = 32'h13; f3 = 2; end
      9: begin fmt = 1; opc = 32'h13; f3 = 3; end
      10: begin fmt = 1; opc = 32'h13; f3 = 4; end
      11: begin fmt = 1; opc = 32'h13; f3 = 6; end
      12: begin fmt = 1; opc = 32'h67; end
      13: begin fmt = 2; opc = 32'h23; f3 = 2; end
      14: begin fmt = 4; opc = 32'h6F; end
      15: begin fmt = 3; opc = 32'h63; end
      16: begin fmt = 3; opc = 32'h63; f3 = 1; end
      17: begin fmt = 3; opc = 32'h63; f3 = 4; end
      18: begin fmt = 3; opc = 32'h63; f3 = 5; end
      19: begin fmt = 5; opc = 32'h37; end
      default: fmt = 6;
    endcase
    regs = (32'(rs1) << 15) | (f3 << 12);
    case (fmt)
      0: golden = (f7 << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | opc;
      1: begin
        golden = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | opc;
        ok = (sv >= -2048) && (sv <= 2047);
      end
      2: begin
        golden = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7) | opc;
        ok = (sv >= -2048) && (sv <= 2047);
      end
      3: begin
        golden = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | regs
               | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | opc;
        ok = (sv >= -4096) && (sv <= 4094) && (sv % 2 == 0);
      end
      4: begin
        golden = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
               | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | opc;
        ok = (sv >= -1048576) && (sv <= 1048574) && (sv % 2 == 0);
      end
      5: begin
        golden = (imm & 32'hFFFFF000) | (32'(rd) << 7) | opc;
        ok = ((imm & 32'hFFF) == 0);
      end
      default: begin
        golden = 32'h0000_0013;
        bad = 1'b1;
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (!ok) bad = 1'b1;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = ST_IDLE; m_cnt[i] = 0; m_addr[i] = 0;
      m_we[i] = 1'b0; m_err[i] = 1'b0; m_wd[i] = 32'd0;
    end
  endfunction

  function automatic void compare_all();
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "u8" : "u2";
      chk({p, ".imem_we"}, 32'(o_we[i]), 32'(m_we[i]));
      chk({p, ".imem_addr"}, o_addr[i], 32'(m_addr[i]));
      chk({p, ".imem_wdata"}, o_wd[i], m_wd[i]);
      chk({p, ".count"}, o_cnt[i], 32'(m_cnt[i]));
      chk({p, ".busy"}, 32'(o_busy[i]), 32'(m_st[i] == ST_RUN));
      chk({p, ".done"}, 32'(o_done[i]), 32'(m_st[i] == ST_DONE));
      chk({p, ".full"}, 32'(o_full[i]), 32'(m_st[i] == ST_FULL));
      chk({p, ".err"}, 32'(o_err[i]), 32'(m_err[i]));
      wr_seen[i] += int'(o_we[i]);
    end
  endfunction

  // Called one time unit after a rising edge with inputs already set; returns at the same phase
  task automatic step();
    bit rdy, acc, b;
    logic [31:0] wd;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy = (m_st[i] == ST_RUN) && !start && (m_cnt[i] + int'(m_we[i]) < cap[i]);
      chk((i == 0) ? "u8.op_ready" : "u2.op_ready", 32'(o_rdy[i]), 32'(rdy));
      acc = rdy && op_valid;
      if (start) begin
        m_st[i] = ST_RUN; m_addr[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0; m_we[i] = 1'b0;
      end else begin
        if (m_we[i]) begin
          m_addr[i] = (m_addr[i] + 1) % cap[i];
          m_cnt[i]++;
          if (m_st[i] == ST_RUN && m_cnt[i] == cap[i]) m_st[i] = ST_FULL;
        end
        m_we[i] = acc;
        if (acc) begin
          wd = golden(op_code, op_rd, op_rs1, op_rs2, op_imm, b);
          m_wd[i] = wd;
          if (b) m_err[i] = 1'b1;
          if (op_last) m_st[i] = ST_DONE;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
  endtask

  task automatic set_op(input int code, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit last);
    start = 1'b0; op_valid = 1'b1; op_last = last;
    op_code = 5'(code); op_rd = 5'(rd); op_rs1 = 5'(rs1); op_rs2 = 5'(rs2); op_imm = imm;
  endtask

  task automatic pulse_start();
    idle();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic async_reset();
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    op_code = 5'd0; op_rd = 5'd0; op_rs1 = 5'd0; op_rs2 = 5'd0; op_imm = 32'd0;
    wr_seen[0] = 0; wr_seen[1] = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    chk("reset_ready", 32'(o_rdy[0]), 32'd0);
    chk("reset_addr", o_addr[0], 32'd0);
    chk("reset_wdata", o_wd[0], 32'd0);
    rst_n = 1'b1;

    // Reference program: addi, sw, beq, lui
    pulse_start();
    set_op(7, 1, 0, 0, 32'd5, 1'b0);
    step();
    chk("addi_we", 32'(o_we[0]), 32'd1);
    chk("addi_wdata", o_wd[0], 32'h00500093);
    chk("addi_addr", o_addr[0], 32'd0);
    set_op(13, 0, 1, 2, 32'd8, 1'b0);
    step();
    chk("addi_count", o_cnt[0], 32'd1);
    chk("sw_wdata", o_wd[0], 32'h0020A423);
    set_op(15, 0, 1, 2, 32'hFFFF_FFFC, 1'b0);
    step();
    chk("beq_wdata", o_wd[0], 32'hFE208EE3);
    set_op(19, 5, 0, 0, 32'h1234_5000, 1'b0);
    step();
    chk("lui_wdata", o_wd[0], 32'h123452B7);
    chk("lui_addr", o_addr[0], 32'd3);
    idle();
    step();
    chk("u2_full_after4", 32'(o_full[1]), 32'd1);
    chk("u2_count4", o_cnt[1], 32'd4);

    // Capacity: five ops streamed into the four-word instance
    pulse_start();
    wr_seen[1] = 0;
    for (int k = 0; k < 5; k++) begin
      set_op(7, k + 1, k, 0, 32'(k), 1'b0);
      step();
    end
    idle();
    step();
    chk("u2_writes", 32'(wr_seen[1]), 32'd4);
    chk("u2_full", 32'(o_full[1]), 32'd1);
    chk("u2_ready_full", 32'(o_rdy[1]), 32'd0);
    pulse_start();
    chk("u2_restart_addr", o_addr[1], 32'd0);
    chk("u2_restart_busy", 32'(o_busy[1]), 32'd1);

    // op_last on the third op, then an illegal op code
    for (int k = 0; k < 3; k++) begin
      set_op(0, 3, 1, 2, 32'd0, k == 2);
      step();
    end
    idle();
    step();
    chk("last_done", 32'(o_done[0]), 32'd1);
    chk("last_count", o_cnt[0], 32'd3);
    set_op(7, 1, 1, 0, 32'd1, 1'b0);
    step();
    chk("done_no_accept", 32'(o_we[0]), 32'd0);
    pulse_start();
    set_op(25, 1, 2, 3, 32'd77, 1'b0);
    step();
    chk("illegal_wdata", o_wd[0], 32'h00000013);
    chk("illegal_err", 32'(o_err[0]), 32'd1);

    // Reset between accept and write
    pulse_start();
    set_op(7, 1, 0, 0, 32'd5, 1'b0);
    step();
    async_reset();
    chk("rst_mid_we", 32'(o_we[0]), 32'd0);
    chk("rst_mid_count", o_cnt[0], 32'd0);

    // Out-of-range I-type immediate
    pulse_start();
    set_op(7, 3, 1, 0, 32'd4096, 1'b0);
    step();
    chk("range_wdata", o_wd[0], 32'h00008193);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_err", 32'(o_err[0]), 32'd1);
`else
    chk("range_err", 32'(o_err[0]), 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        continue;
      end
      start    = ($urandom_range(0, 99) < 4);
      op_valid = ($urandom_range(0, 99) < 75);
      op_last  = ($urandom_range(0, 19) == 0);
      op_code  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      op_rd    = 5'($urandom);
      op_rs1   = 5'($urandom);
      op_rs2   = 5'($urandom);
      case ($urandom_range(0, 3))
        0: op_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: op_imm = 32'($urandom);
        2: op_imm = 32'($urandom) & 32'hFFFF_F000;
        default: op_imm = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
